// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) types, frame constants and the encoder function used by
// both ends of the serial link.
package hamming74_pkg;

  localparam int unsigned CW_BITS   = 7;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned SLOT_W    = 3;

  typedef logic [3:0]         nibble_t;
  typedef logic [CW_BITS-1:0] codeword_t;
  typedef logic [SLOT_W-1:0]  slot_t;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } tx_state_e;

  // Slot 7 carries the guard bit; slot 6 is the last codeword bit.
  localparam slot_t LAST_SLOT      = slot_t'(FRAME_LEN - 1);
  localparam slot_t LAST_DATA_SLOT = slot_t'(CW_BITS - 1);

  function automatic codeword_t hamming74_encode(input nibble_t d);
    codeword_t c;
    c[0] = d[0];
    c[1] = d[1];
    c[2] = d[2];
    c[3] = d[2] ^ d[1] ^ d[0];
    c[4] = d[3];
    c[5] = d[3] ^ d[1] ^ d[0];
    c[6] = d[3] ^ d[2] ^ d[0];
    return c;
  endfunction

endpackage

// File: rtl/hamming74_nibble_fifo.sv
// Synchronous nibble FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable with a power-of-two depth.
module hamming74_nibble_fifo
  import hamming74_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  nibble_t wdata,
  input  logic    pop,
  output nibble_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [AW:0] ptr_t;

  ptr_t    wptr_q, wptr_d;
  ptr_t    rptr_q, rptr_d;
  nibble_t mem_q [FIFO_DEPTH];
  logic    do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      wptr_d = wptr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) transmitter: buffers nibbles, encodes them and serialises each
// codeword LSB first as an 8-slot frame terminated by a guard bit.
module hamming74_encoder_tx
  import hamming74_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic        GUARD_VAL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       encode_out,
  output logic       frame_start,
  output logic       busy
);

  tx_state_e state_q, state_d;
  slot_t     slot_q, slot_d;
  codeword_t shift_q, shift_d;
  logic      encode_q, encode_d;
  logic      frame_start_q, frame_start_d;

  logic      fifo_push, fifo_pop;
  logic      fifo_full, fifo_empty;
  nibble_t   fifo_head;
  codeword_t head_cw;

  // Gated by rst_n so the handshake stays closed while the block is held in reset.
  assign data_ready = rst_n && ena && !fifo_full;
  assign fifo_push  = data_valid && data_ready;
  assign head_cw    = hamming74_encode(fifo_head);

  hamming74_nibble_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(data_in),
    .pop  (fifo_pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shift_d       = shift_q;
    encode_d      = encode_q;
    frame_start_d = frame_start_q;
    fifo_pop      = 1'b0;

    if (ena) begin
      unique case (state_q)
        StIdle: begin
          encode_d      = GUARD_VAL;
          frame_start_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            state_d       = StSend;
            slot_d        = '0;
            shift_d       = head_cw;
            encode_d      = head_cw[0];
            frame_start_d = 1'b1;
          end
        end
        StSend: begin
          frame_start_d = 1'b0;
          if (slot_q == LAST_SLOT) begin
            if (!fifo_empty) begin
              // Back-to-back frame: the next slot 0 follows the guard directly.
              fifo_pop      = 1'b1;
              slot_d        = '0;
              shift_d       = head_cw;
              encode_d      = head_cw[0];
              frame_start_d = 1'b1;
            end else begin
              state_d  = StIdle;
              slot_d   = '0;
              encode_d = GUARD_VAL;
            end
          end else begin
            slot_d   = slot_q + slot_t'(1);
            shift_d  = shift_q >> 1;
            encode_d = (slot_q == LAST_DATA_SLOT) ? GUARD_VAL : shift_q[1];
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      slot_q        <= '0;
      shift_q       <= '0;
      encode_q      <= GUARD_VAL;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shift_q       <= shift_d;
      encode_q      <= encode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign encode_out  = encode_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == StSend) || !fifo_empty;

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Directed bench for hamming74_encoder_tx: framing, latency, back-pressure,
// enable stalls, mid-frame reset and a full 16-nibble decode sweep.
module tb_hamming74_encoder_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       encode_out;
  logic       frame_start;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] bits;
  int         lat;
  bit         w;
  bit         any_wait;
  int         n;
  int         cnt;

  logic [3:0] vec5 [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
  logic [7:0] exp5 [5] = '{8'h69, 8'h2A, 8'h4C, 8'h70, 8'h66};

  hamming74_encoder_tx #(
    .FIFO_DEPTH(2),
    .GUARD_VAL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .encode_out (encode_out),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [3:0] d, output bit waited);
    int k = 0;
    waited     = 1'b0;
    data_in    = d;
    data_valid = 1'b1;
    while (!data_ready && k < 100) begin
      waited = 1'b1;
      @(negedge clk);
      k++;
    end
    check("push_timeout", k < 100, 1);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Waits for frame_start (bounded) and collects 8 slots, ending on slot 7.
  task automatic capture(input string tag, output logic [7:0] b, output int latency);
    int  k     = 0;
    bit  extra = 1'b0;
    while (!frame_start && k < 60) begin
      @(negedge clk);
      k++;
    end
    latency = k;
    check({tag, "_start"}, frame_start, 1);
    b[0] = encode_out;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      b[i] = encode_out;
      if (frame_start) extra = 1'b1;
    end
    check({tag, "_fs_once"}, extra, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    data_valid = 1'b0;
    data_in    = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {encode_out, frame_start, busy, data_ready}, 4'b0000);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready_busy", {data_ready, busy}, 2'b10);
    @(negedge clk);

    // Single nibble 1011 -> 1,1,0,0,1,1,0 then guard.
    push(4'hB, w);
    check("t1_busy_after_push", busy, 1);
    capture("t1", bits, lat);
    check("t1_latency", lat, 1);
    check("t1_bits", bits, 8'h33);
    @(negedge clk);
    check("t1_idle", {encode_out, frame_start, busy}, 3'b000);

    // Back-to-back 0 then F with no gap between frames.
    push(4'h0, w);
    push(4'hF, w);
    capture("t2a", bits, lat);
    check("t2a_bits", bits, 8'h00);
    capture("t2b", bits, lat);
    check("t2b_gap", lat, 1);
    check("t2b_bits", bits, 8'h7F);
    @(negedge clk);
    check("t2_idle", busy, 0);

    // Five nibbles with data_valid held high against a depth-2 FIFO.
    any_wait = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          bit pw;
          push(vec5[k], pw);
          any_wait |= pw;
        end
      end
      begin
        for (int k = 0; k < 5; k++) begin
          capture($sformatf("t3_f%0d", k), bits, lat);
          check($sformatf("t3_bits%0d", k), bits, exp5[k]);
          if (k > 0) check($sformatf("t3_gap%0d", k), lat, 1);
        end
      end
    join
    check("t3_backpressure", any_wait, 1);
    @(negedge clk);
    check("t3_idle", busy, 0);

    // Enable stall for 3 cycles while slot 3 of 1011 is on the line.
    push(4'hB, w);
    n = 0;
    while (!frame_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t4_start", frame_start, 1);
    bits[0] = encode_out;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      bits[i] = encode_out;
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", i), {encode_out, frame_start, data_ready, busy}, 4'b0001);
    end
    ena = 1'b1;
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      bits[i] = encode_out;
    end
    check("t4_bits", bits, 8'h33);
    @(negedge clk);
    check("t4_idle", {encode_out, busy}, 2'b00);

    // Reset at slot 5 with a second nibble still buffered.
    push(4'hB, w);
    push(4'h6, w);
    check("t5_start", frame_start, 1);
    repeat (5) @(negedge clk);
    check("t5_slot5_bit", encode_out, 1);
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {encode_out, frame_start, busy, data_ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_start || busy || encode_out) cnt++;
    end
    check("t5_quiet_after_reset", cnt, 0);
    push(4'h8, w);
    capture("t5_new", bits, lat);
    check("t5_new_latency", lat, 1);
    check("t5_new_bits", bits, 8'h70);
    @(negedge clk);

    // Sweep all 16 nibbles through a bench-side decoder aligned on frame_start.
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          bit pw;
          push(4'(k), pw);
        end
      end
      begin
        for (int k = 0; k < 16; k++) begin
          logic [2:0] syn;
          logic [3:0] dec;
          logic [3:0] kk;
          capture($sformatf("t6_f%0d", k), bits, lat);
          syn = {bits[6] ^ bits[4] ^ bits[2] ^ bits[0],
                 bits[5] ^ bits[4] ^ bits[1] ^ bits[0],
                 bits[3] ^ bits[2] ^ bits[1] ^ bits[0]};
          dec = {bits[4], bits[2], bits[1], bits[0]};
          kk  = 4'(k);
          check($sformatf("t6_decode%0d", k), {syn, dec, bits[7]}, {3'b000, kk, 1'b0});
          if (k > 0) check($sformatf("t6_gap%0d", k), lat, 1);
        end
      end
    join
    @(negedge clk);
    check("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
